mem_port_arbiter: RTL and testbench

Sequences the single-port data RAM behind the EX/MEM stage and shares it between the MEM-stage data access and the IF-stage instruction fetch. Converts ReadMem/WriteMem/quarter control into RAM cycles, including read-modify-write for quarter (nibble) stores. Drives a stall to freeze the pipeline latches while a data access is in flight.

---
 rtl/cpu_mem_pkg.sv | 26 ++
 rtl/mem_nibble_merge.sv | 24 ++
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the MEM-stage RAM port: ReadMem encodings, arbiter
// states and nibble geometry.
package cpu_mem_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NIB_CNT = DATA_W / NIB_W;
    localparam int unsigned QSEL_W  = 2;
    localparam int unsigned LAT_W   = 3;

    typedef enum logic [1:0] {
        RM_NONE    = 2'b00,
        RM_WORD    = 2'b01,
        RM_QUARTER = 2'b10
    } read_mem_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D_RD,
        ST_D_RMW_RD,
        ST_D_RMW_WR,
        ST_D_WR,
        ST_I_RD
    } arb_state_e;

endpackage

// File: rtl/mem_nibble_merge.sv
// Quarter (nibble) extract and insert on a 16-bit word; shared by the
// quarter-read return path and the read-modify-write store path.
module mem_nibble_merge
    import cpu_mem_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [QSEL_W-1:0] sel_i,
    input  logic [NIB_W-1:0]  nib_i,
    output logic [NIB_W-1:0]  nib_o,
    output logic [DATA_W-1:0] merged_o
);

    always_comb begin
        nib_o    = '0;
        merged_o = word_i;
        for (int unsigned n = 0; n < NIB_CNT; n++) begin
            if (sel_i == QSEL_W'(n)) begin
                nib_o                     = word_i[n*NIB_W +: NIB_W];
                merged_o[n*NIB_W +: NIB_W] = nib_i;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data RAM sequencer shared between MEM-stage data and IF fetch.
// Optional perf counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   d_addr,
    input  logic [1:0]          d_read_mem,
    input  logic                d_write_mem,
    input  logic [QSEL_W-1:0]   d_quarter,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                stall_mem,
    input  logic                i_req,
    input  logic [DATA_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_valid,
    output logic [DATA_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_re,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]         perf_stall_cnt,
    output logic [15:0]         perf_fetch_wait_cnt
`endif
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_e          state_q;
    logic [LAT_W-1:0]    lat_q;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [DATA_W-1:0]   addr_q;
    logic [QSEL_W-1:0]   qsel_q;
    logic [NIB_W-1:0]    wnib_q;
    logic                rd_quarter_q;

    logic [DATA_W-1:0]   ram_addr_q, ram_wdata_q;
    logic                ram_re_q, ram_we_q;
    logic                d_done_q, i_valid_q;

    logic                d_req, fetch_first, take_d, take_i;
    logic [NIB_W-1:0]    rd_nib;
    logic [DATA_W-1:0]   merged;

    mem_nibble_merge u_merge (
        .word_i   (ram_rdata),
        .sel_i    (qsel_q),
        .nib_i    (wnib_q),
        .nib_o    (rd_nib),
        .merged_o (merged)
    );

    always_comb begin
        d_req       = d_write_mem | (d_read_mem != RM_NONE);
        fetch_first = (starve_q == STARVE_W'(STARVE_MAX)) && i_req;
        take_d      = (state_q == ST_IDLE) && d_req && !fetch_first;
        take_i      = (state_q == ST_IDLE) && i_req && !take_d;
        starve_d    = starve_q;
        if (take_i) begin
            starve_d = '0;
        end else if (i_req && (starve_q != STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lat_q        <= '0;
            starve_q     <= '0;
            addr_q       <= '0;
            qsel_q       <= '0;
            wnib_q       <= '0;
            rd_quarter_q <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_re_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_valid_q    <= 1'b0;
        end else begin
            // Strobes and bus values are single-cycle; each state re-asserts what it needs.
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_valid_q   <= 1'b0;
            starve_q    <= starve_d;

            case (state_q)
                ST_IDLE: begin
                    if (take_d) begin
                        addr_q       <= d_addr;
                        qsel_q       <= d_quarter;
                        wnib_q       <= d_wdata[NIB_W-1:0];
                        rd_quarter_q <= (d_read_mem == RM_QUARTER);
                        lat_q        <= '0;
                        ram_addr_q   <= d_addr;
                        if (d_write_mem && (d_read_mem == RM_QUARTER)) begin
                            state_q  <= ST_D_RMW_RD;
                            ram_re_q <= 1'b1;
                        end else if (d_write_mem) begin
                            state_q     <= ST_D_WR;
                            ram_we_q    <= 1'b1;
                            ram_wdata_q <= d_wdata;
                            d_done_q    <= 1'b1;
                        end else begin
                            state_q  <= ST_D_RD;
                            ram_re_q <= 1'b1;
                        end
                    end else if (take_i) begin
                        state_q    <= ST_I_RD;
                        lat_q      <= '0;
                        ram_re_q   <= 1'b1;
                        ram_addr_q <= i_addr;
                    end
                end

                ST_D_RD, ST_I_RD: begin
                    // lat_q counts from the strobe cycle; the pulse lands when read data is valid.
                    if (lat_q == LAT_W'(RAM_LAT)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                        if (lat_q == LAT_W'(RAM_LAT - 1)) begin
                            if (state_q == ST_D_RD) begin
                                d_done_q <= 1'b1;
                            end else begin
                                i_valid_q <= 1'b1;
                            end
                        end
                    end
                end

                ST_D_RMW_RD: begin
                    if (lat_q == LAT_W'(RAM_LAT)) begin
                        state_q     <= ST_D_RMW_WR;
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= addr_q;
                        ram_wdata_q <= merged;
                        d_done_q    <= 1'b1;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end

                ST_D_RMW_WR, ST_D_WR: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low while rst is high so an aborted access cannot strobe or complete.
    always_comb begin
        ram_addr  = rst ? '0 : ram_addr_q;
        ram_wdata = rst ? '0 : ram_wdata_q;
        ram_re    = ram_re_q & ~rst;
        ram_we    = ram_we_q & ~rst;
        d_done    = d_done_q & ~rst;
        i_valid   = i_valid_q & ~rst;
        stall_mem = d_req & ~d_done_q & ~rst;
        d_rdata   = '0;
        if (d_done_q && (state_q == ST_D_RD) && !rst) begin
            d_rdata = rd_quarter_q ? {{(DATA_W-NIB_W){1'b0}}, rd_nib} : ram_rdata;
        end
        i_rdata = (i_valid_q && !rst) ? ram_rdata : '0;
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_stall_q;
    logic [15:0] perf_wait_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            if (stall_mem && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
            if (i_req && !take_i && (perf_wait_q != '1)) begin
                perf_wait_q <= perf_wait_q + 16'd1;
            end
        end
    end

    assign perf_stall_cnt      = rst ? '0 : perf_stall_q;
    assign perf_fetch_wait_cnt = rst ? '0 : perf_wait_q;
`endif

    a_no_re_we: assert property (@(posedge clk) disable iff (rst) !(ram_re && ram_we));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level reference model
// predicts every output per cycle from fixed access latencies.
module tb_mem_port_arbiter;

    localparam int LAT  = 1;
    localparam int SMAX = 4;
    localparam int NCYC = 4000;

    localparam int K_WRD = 0;
    localparam int K_QRD = 1;
    localparam int K_WWR = 2;
    localparam int K_QWR = 3;
    localparam int K_FET = 4;

    logic        clk;
    logic        rst;
    logic [15:0] d_addr;
    logic [1:0]  d_read_mem;
    logic        d_write_mem;
    logic [1:0]  d_quarter;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        stall_mem;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_valid;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_re;
    logic        ram_we;
    logic [15:0] ram_rdata;

    mem_port_arbiter #(.RAM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_addr     (d_addr),
        .d_read_mem (d_read_mem),
        .d_write_mem(d_write_mem),
        .d_quarter  (d_quarter),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .stall_mem  (stall_mem),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_valid    (i_valid),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_re     (ram_re),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM behind the port: contents and next read pipeline are updated by the main process.
    logic [15:0] ram     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] pipe    [LAT];
    logic [15:0] pipe_n  [LAT];

    always @(posedge clk) begin
        for (int k = 0; k < LAT; k++) pipe[k] <= pipe_n[k];
    end
    assign ram_rdata = pipe[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    bit          act;
    int          kind, t0, m_end, starve;
    logic [15:0] m_addr, m_wdata, m_rdata;

    // Requester state
    bit          rq_act, fq_act, prev_done, prev_valid, holdoff, rst_now, rmw_rst_done;
    logic [1:0]  rq_rm, rq_q;
    bit          rq_we;
    logic [15:0] rq_a, rq_wd, fq_a;

    // Scripted opening transactions
    logic [1:0]  s_rm [4];
    bit          s_we [4];
    logic [15:0] s_a  [4];
    logic [1:0]  s_q  [4];
    logic [15:0] s_wd [4];
    int          sidx;

    task automatic rand_dop();
        int k, r;
        k     = $urandom_range(0, 3);
        rq_q  = 2'($urandom);
        rq_wd = 16'($urandom);
        rq_a  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
        case (k)
            0: begin rq_we = 1'b0; rq_rm = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b11; end
            1: begin rq_we = 1'b0; rq_rm = 2'b10; end
            2: begin
                rq_we = 1'b1;
                r     = $urandom_range(0, 2);
                rq_rm = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
            end
            default: begin rq_we = 1'b1; rq_rm = 2'b10; end
        endcase
    endtask

    initial begin
        logic [15:0] v;
        bit          e_re, e_we, e_done, e_valid, e_stall, gi, dreq;
        logic [15:0] e_addr, e_wdata, e_rdata, e_irdata;
        int          off, pd, pi, q4, diffs;

        for (int a = 0; a < 65536; a++) begin
            v = 16'($urandom);
            ram[a] = v;
            ref_mem[a] = v;
        end
        ram[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
        ram[16'h0020] = 16'h1A5C; ref_mem[16'h0020] = 16'h1A5C;
        ram[16'h0030] = 16'h1234; ref_mem[16'h0030] = 16'h1234;
        ram[16'h0040] = 16'hC0DE; ref_mem[16'h0040] = 16'hC0DE;
        for (int k = 0; k < LAT; k++) pipe_n[k] = 16'h0;

        s_rm[0] = 2'b01; s_we[0] = 1'b0; s_a[0] = 16'h0010; s_q[0] = 2'd0; s_wd[0] = 16'h0;
        s_rm[1] = 2'b10; s_we[1] = 1'b0; s_a[1] = 16'h0020; s_q[1] = 2'd2; s_wd[1] = 16'h0;
        s_rm[2] = 2'b10; s_we[2] = 1'b1; s_a[2] = 16'h0030; s_q[2] = 2'd1; s_wd[2] = 16'h0007;
        s_rm[3] = 2'b01; s_we[3] = 1'b0; s_a[3] = 16'h0030; s_q[3] = 2'd0; s_wd[3] = 16'h0;
        sidx = 0;

        rst = 1'b1;
        d_addr = '0; d_read_mem = '0; d_write_mem = 1'b0; d_quarter = '0; d_wdata = '0;
        i_req = 1'b0; i_addr = '0;
        act = 0; starve = 0; rq_act = 0; fq_act = 0; prev_done = 0; prev_valid = 0;
        holdoff = 0; rmw_rst_done = 0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            if (prev_done)  rq_act = 0;
            if (prev_valid) fq_act = 0;

            pd = (cyc < 1500) ? 60 : ((cyc < 2500) ? 100 : 30);
            pi = (cyc < 1500) ? 40 : ((cyc < 2500) ? 100 : 70);

            rst_now = (cyc < 3);
            if (!rmw_rst_done && cyc > 100 && act && kind == K_QWR && (cyc - t0) == 2) begin
                rst_now = 1;
                rmw_rst_done = 1;
            end
            if (cyc > 50 && $urandom_range(0, 199) == 0) rst_now = 1;

            if (rst_now) begin
                rq_act = 0; fq_act = 0; holdoff = 1;
            end else if (holdoff) begin
                holdoff = 0;
            end else begin
                if (!rq_act) begin
                    if (sidx < 4) begin
                        rq_rm = s_rm[sidx]; rq_we = s_we[sidx]; rq_a = s_a[sidx];
                        rq_q = s_q[sidx]; rq_wd = s_wd[sidx];
                        rq_act = 1;
                        if (sidx == 0) begin fq_act = 1; fq_a = 16'h0040; end
                        sidx++;
                    end else if ($urandom_range(0, 99) < pd) begin
                        rand_dop();
                        rq_act = 1;
                    end
                end
                if (!fq_act && $urandom_range(0, 99) < pi) begin
                    fq_act = 1;
                    fq_a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
                end
            end

            rst         = rst_now;
            d_read_mem  = rq_act ? rq_rm : 2'b00;
            d_write_mem = rq_act ? rq_we : 1'b0;
            d_addr      = rq_act ? rq_a  : 16'($urandom);
            d_quarter   = rq_act ? rq_q  : 2'($urandom);
            d_wdata     = rq_act ? rq_wd : 16'($urandom);
            i_req       = fq_act;
            i_addr      = fq_act ? fq_a : 16'($urandom);
            #1;

            e_re = 0; e_we = 0; e_done = 0; e_valid = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; e_irdata = '0;
            off = cyc - t0;
            if (!rst_now && act) begin
                if (off == 1) begin
                    e_addr = m_addr;
                    if (kind == K_WWR) begin
                        e_we = 1; e_wdata = m_wdata; e_done = 1;
                    end else begin
                        e_re = 1;
                    end
                end
                if ((kind == K_WRD || kind == K_QRD) && off == 1 + LAT) begin
                    e_done = 1; e_rdata = m_rdata;
                end
                if (kind == K_FET && off == 1 + LAT) begin
                    e_valid = 1; e_irdata = m_rdata;
                end
                if (kind == K_QWR && off == 2 + LAT) begin
                    e_we = 1; e_addr = m_addr; e_wdata = m_wdata; e_done = 1;
                end
            end
            dreq    = d_write_mem || (d_read_mem != 2'b00);
            e_stall = !rst_now && dreq && !e_done;

            check_val("d_done",    16'(d_done),    16'(e_done));
            check_val("d_rdata",   d_rdata,        e_rdata);
            check_val("stall_mem", 16'(stall_mem), 16'(e_stall));
            check_val("i_valid",   16'(i_valid),   16'(e_valid));
            check_val("i_rdata",   i_rdata,        e_irdata);
            check_val("ram_re",    16'(ram_re),    16'(e_re));
            check_val("ram_we",    16'(ram_we),    16'(e_we));
            check_val("ram_addr",  ram_addr,       e_addr);
            check_val("ram_wdata", ram_wdata,      e_wdata);

            if (rst_now) begin
                act = 0;
                starve = 0;
            end else begin
                gi = 0;
                if (act) begin
                    if (off == m_end) begin
                        act = 0;
                        if (kind == K_WWR || kind == K_QWR) ref_mem[m_addr] = m_wdata;
                    end
                end else if (dreq && !(starve == SMAX && i_req)) begin
                    act = 1; t0 = cyc; m_addr = d_addr;
                    q4 = 4 * int'(d_quarter);
                    if (d_write_mem && d_read_mem == 2'b10) begin
                        kind = K_QWR; m_end = 2 + LAT;
                        m_wdata = (ref_mem[d_addr] & ~(16'hF << q4)) | ((d_wdata & 16'hF) << q4);
                    end else if (d_write_mem) begin
                        kind = K_WWR; m_end = 1; m_wdata = d_wdata;
                    end else if (d_read_mem == 2'b10) begin
                        kind = K_QRD; m_end = 1 + LAT;
                        m_rdata = (ref_mem[d_addr] >> q4) & 16'hF;
                    end else begin
                        kind = K_WRD; m_end = 1 + LAT; m_rdata = ref_mem[d_addr];
                    end
                end else if (i_req) begin
                    act = 1; t0 = cyc; m_addr = i_addr; kind = K_FET; m_end = 1 + LAT;
                    m_rdata = ref_mem[i_addr];
                    gi = 1;
                end
                if (gi) starve = 0;
                else if (i_req && starve < SMAX) starve++;
            end
            prev_done  = e_done;
            prev_valid = e_valid;

            if (ram_we) ram[ram_addr] = ram_wdata;
            for (int k = LAT - 1; k > 0; k--) pipe_n[k] = pipe[k-1];
            pipe_n[0] = ram_re ? ram[ram_addr] : 16'($urandom);
        end

        for (int a = 0; a < 64; a++) check_val("mem_word", ram[a], ref_mem[a]);
        diffs = 0;
        for (int a = 0; a < 65536; a++) if (ram[a] !== ref_mem[a]) diffs++;
        check_val("mem_diffs", 16'(diffs), 16'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
